serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, LSB-first adder for two WIDTH-bit unsigned operands.
- Each bit slice is a full adder built from two cascaded half-adder stages; the carry is held in a flop between cycles.
- Loads operands on a start pulse, then shifts one bit per clock through the half-adder pair. Returns a registered WIDTH-bit sum plus carry-out with a one-cycle done strobe.
- Sits directly upstream of the half-adder cells: it sequences operand bits into them and consumes their sum/carry outputs. Intended as the area-cheap arithmetic path where throughput is not critical.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range ≥ 1.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle request; sampled only in IDLE.
- i_operand_a  input  WIDTH  addend A; sampled with an accepted i_start.
- i_operand_b  input  WIDTH  addend B; sampled with an accepted i_start.
- o_busy  output  1  high while in SHIFT.
- o_done  output  1  one-cycle strobe; result valid.
- o_sum  output  WIDTH  registered (A+B) mod 2^WIDTH.
- o_carry  output  1  registered carry-out of the MSB.

Behaviour:
- Reset (i_rst_n low, asynchronous): state=IDLE. o_busy=0, o_done=0, o_sum=0, o_carry=0. Operand shift registers, carry flop and bit counter all cleared.
- Reset is released synchronously to i_clk, inside the reset synchroniser, outside this block.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - i_start=1 at edge E0: load A and B into shift registers, clear the carry flop and bit counter, go to SHIFT.
  - i_start=0: stay in IDLE.
- SHIFT, each edge:
  - Half adder 1: s1 = a0^b0, c1 = a0&b0.
  - Half adder 2: bit = s1^c, c2 = s1&c.
  - Next carry = c1|c2.
  - bit shifts into the MSB of the internal result register (shift right).
  - A and B shift right by one.
  - Counter increments.
- SHIFT exit: at the edge that processes bit WIDTH-1 (edge E_WIDTH), go to DONE. On the same edge, copy the result register to o_sum and the next carry to o_carry.
- DONE: o_done=1 for exactly this one cycle; next edge returns to IDLE unconditionally.
- Latency: o_done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accepting edge.
- Throughput: one addition per WIDTH+2 cycles, start-to-start minimum.
- o_busy = (state==SHIFT), combinational decode of the state register.
- o_sum/o_carry:
  - Change only on the SHIFT→DONE edge.
  - Hold the last result until the next completion or reset.
  - Intermediate bits are never visible on them.
- i_start while in SHIFT or DONE: ignored, no queueing. Operand inputs are don't-care outside the accepting edge.
- Reset mid-operation: aborts immediately. No o_done is generated; outputs return to 0.
- Arithmetic: unsigned. {o_carry, o_sum} = A + B exactly, with WIDTH+1 bits.
- Counter width: $clog2(WIDTH+1). WIDTH=1 must work: a single SHIFT cycle.
- No X on any output after reset, regardless of input values.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, start pulse:
  - o_busy high 8 cycles.
  - o_done single pulse 8 cycles after the accepting edge.
  - o_sum=0x08, o_carry=0.
- A=0xFF, B=0x01 → o_sum=0x00, o_carry=1 (full carry ripple). Then A=0xFF, B=0xFF → o_sum=0xFE, o_carry=1.
- Start 0x10+0x20, then pulse i_start with 0x7F+0x7F at cycles 3 and DONE:
  - Both pulses ignored.
  - Result 0x30, carry 0.
  - Next IDLE start is accepted normally.
- Start 0xAA+0x55, assert i_rst_n low at cycle 4:
  - All outputs 0 asynchronously; no o_done.
  - After release, 0x01+0x01 → 0x02.
- Back-to-back: start asserted on the first IDLE cycle after each done. Run 100 random A/B pairs and compare {o_carry, o_sum} to A+B. Previous result holds until the next o_done.
- WIDTH=1 build: all 4 input combinations give correct {carry, sum} after 1 SHIFT cycle. o_busy is high for exactly 1 cycle.

Source files
------------

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done strobes and the registered sum/carry out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;

    modport master (
        output i_start, i_operand_a, i_operand_b,
        input  o_busy, o_done, o_sum, o_carry
    );

    modport slave (
        input  i_start, i_operand_a, i_operand_b,
        output o_busy, o_done, o_sum, o_carry
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first unsigned adder: one full-adder slice (two half adders)
// per clock, carry kept in a flop, result published once on completion.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    logic [1:0]       ha1;
    logic [1:0]       ha2;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;

    // Returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    always_comb begin
        ha1       = half_add(a_sr[0], b_sr[0]);
        ha2       = half_add(ha1[0], carry_q);
        carry_nxt = ha1[1] | ha2[1];
        res_nxt   = res_sr >> 1;
        res_nxt[WIDTH-1] = ha2[0];
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        a_sr    <= bus.i_operand_a;
                        b_sr    <= bus.i_operand_b;
                        res_sr  <= '0;
                        carry_q <= 1'b0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_nxt;
                    carry_q <= carry_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    // Outputs only ever see the completed word.
                    if (last_bit) begin
                        state       <= DONE;
                        done_q      <= 1'b1;
                        sum_q       <= res_nxt;
                        carry_out_q <= carry_nxt;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy  = (state == SHIFT);
    assign bus.o_done  = done_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = carry_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances, table vectors,
// scoreboard-checked results and hand-written start/reset corner sequences.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
    } vec_t;

    vec_t       vecs [7];
    logic [8:0] exp_q [$];
    logic [8:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation,
    // and the published result must hold between completions.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = '0;
        end else if (bus8.o_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result", {bus8.o_carry, bus8.o_sum}, exp_q.pop_front());
            end
            last_res = {bus8.o_carry, bus8.o_sum};
        end else begin
            check("hold", {bus8.o_carry, bus8.o_sum}, last_res);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Called on a negedge; returns on the negedge after the done strobe.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        int  n;
        int  busy_n;
        bit  got;
        n = 0;
        while ((bus8.o_busy || bus8.o_done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        bus8.i_start     = 1'b1;
        bus8.i_operand_a = a;
        bus8.i_operand_b = b;
        exp_q.push_back(exp);
        @(negedge clk);
        bus8.i_start     = 1'b0;
        bus8.i_operand_a = 8'($urandom);
        bus8.i_operand_b = 8'($urandom);
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (n < 30) begin
            if (bus8.o_done) begin
                got = 1'b1;
                break;
            end
            if (bus8.o_busy) busy_n++;
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", n, 32'd8);
        check("busy_cycles", busy_n, 32'd8);
        @(negedge clk);
        check("done_pulse", bus8.o_done, 32'd0);
    endtask

    initial begin
        int  n;
        int  busy_n;
        bit  got;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{a: 8'h05, b: 8'h03, sum: 8'h08, carry: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1};
        vecs[5] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, carry: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, carry: 1'b0};

        bus8.i_start = 1'b0; bus8.i_operand_a = '0; bus8.i_operand_b = '0;
        bus1.i_start = 1'b0; bus1.i_operand_a = '0; bus1.i_operand_b = '0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus8.o_busy, 32'd0);
        check("rst_done", bus8.o_done, 32'd0);
        check("rst_sum", bus8.o_sum, 32'd0);
        check("rst_carry", bus8.o_carry, 32'd0);
        check("rst_w1_out", {bus1.o_busy, bus1.o_done, bus1.o_carry, bus1.o_sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            do_add(vecs[i].a, vecs[i].b, {vecs[i].carry, vecs[i].sum});

        // Starts during SHIFT and DONE must be ignored.
        bus8.i_start = 1'b1; bus8.i_operand_a = 8'h10; bus8.i_operand_b = 8'h20;
        exp_q.push_back(9'h030);
        @(negedge clk);
        bus8.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.i_start = 1'b1; bus8.i_operand_a = 8'h7F; bus8.i_operand_b = 8'h7F;
        @(negedge clk);
        bus8.i_start = 1'b0;
        n = 0;
        while (!bus8.o_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ign_done_seen", 32'(bus8.o_done), 32'd1);
        bus8.i_start = 1'b1;
        @(negedge clk);
        bus8.i_start = 1'b0;
        check("ign_busy_after_done", bus8.o_busy, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("ign_stays_idle", bus8.o_busy, 32'd0);
        end
        do_add(8'h12, 8'h34, 9'h046);

        // Reset mid-operation aborts without a done.
        bus8.i_start = 1'b1; bus8.i_operand_a = 8'hAA; bus8.i_operand_b = 8'h55;
        @(negedge clk);
        bus8.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", bus8.o_busy, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", bus8.o_busy, 32'd0);
        check("abort_done", bus8.o_done, 32'd0);
        check("abort_sum", bus8.o_sum, 32'd0);
        check("abort_carry", bus8.o_carry, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", exp_q.size(), 32'd0);
        do_add(8'h01, 8'h01, 9'h002);

        // Back-to-back random operations.
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_add(ra, rb, {1'b0, ra} + {1'b0, rb});
        end
        check("queue_drained", exp_q.size(), 32'd0);

        // WIDTH=1 instance: all input combinations.
        for (int i = 0; i < 4; i++) begin
            logic xa;
            logic xb;
            xa = i[1];
            xb = i[0];
            bus1.i_start = 1'b1; bus1.i_operand_a = xa; bus1.i_operand_b = xb;
            @(negedge clk);
            bus1.i_start = 1'b0;
            n = 0; busy_n = 0; got = 1'b0;
            while (n < 10) begin
                if (bus1.o_done) begin
                    got = 1'b1;
                    break;
                end
                if (bus1.o_busy) busy_n++;
                @(negedge clk);
                n++;
            end
            check("w1_done_seen", 32'(got), 32'd1);
            check("w1_latency", n, 32'd1);
            check("w1_busy_cycles", busy_n, 32'd1);
            check("w1_result", {bus1.o_carry, bus1.o_sum}, {1'b0, xa} + {1'b0, xb});
            @(negedge clk);
            check("w1_done_pulse", bus1.o_done, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
